// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bus for bcd_serial_addsub.
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both high. The source holds its payload
// stable while valid is high and ready is low.
//
// Signals:
//   in_valid/in_ready  : operand channel (a, b, sub, cin)
//   out_valid/out_ready: result channel (sum, cout, err)
// Modports:
//   master : operand producer / result consumer
//   slave  : the adder/subtractor
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  sub;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor.
//
// Takes two DIGITS-digit packed BCD operands and processes one digit per
// clock, least significant digit first, through one decimal-correction
// stage. Subtraction uses nine's complement of B plus an initial carry of 1,
// so cout=1 means "no borrow" (A >= B) and cout=0 leaves the ten's
// complement of (B-A) in sum. err flags any operand digit above 9; it does
// not change the arithmetic.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : operand/result handshake bus (slave side)
//   state_dbg : current FSM state (0=IDLE, 1=CALC, 2=DONE)
module bcd_serial_addsub #(
  parameter int DIGITS = 4,
  parameter int CW     = $clog2(DIGITS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_addsub_if.slave    bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       idx;
  logic [4*DIGITS-1:0] a_r, b_r, sum_r;
  logic                sub_r, carry, cout_r, err_r;

  logic                accept, last_digit, in_err;
  logic [3:0]          a_d, b_d, bd, sum_d;
  logic [4:0]          s;
  logic                carry_d;

  assign accept     = bus.in_valid && (state == IDLE);
  assign last_digit = (idx == CW'(DIGITS - 1));

  // Any operand digit above 9 is flagged at accept time.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  // One digit of decimal add. 9-b_d is plain 4-bit arithmetic, so it wraps
  // for illegal digits; the result is then deterministic but meaningless.
  always_comb begin
    a_d   = a_r[4*idx +: 4];
    b_d   = b_r[4*idx +: 4];
    bd    = sub_r ? (4'd9 - b_d) : b_d;
    s     = {1'b0, a_d} + {1'b0, bd} + {4'b0000, carry};
    sum_d = s[3:0];
    carry_d = 1'b0;
    if (s >= 5'd10) begin
      sum_d   = s[3:0] + 4'd6;
      carry_d = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (last_digit) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sub_r  <= 1'b0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (accept) begin
      a_r    <= bus.a;
      b_r    <= bus.b;
      sub_r  <= bus.sub;
      carry  <= bus.sub ? 1'b1 : bus.cin;
      err_r  <= in_err;
      idx    <= '0;
    end else if (state == CALC) begin
      sum_r[4*idx +: 4] <= sum_d;
      carry <= carry_d;
      idx   <= idx + CW'(1);
      if (last_digit) cout_r <= carry_d;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.err       = err_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;
  localparam int DIGITS = 4;
  localparam int W      = 4*DIGITS + 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         cyc;
  int         errors;
  int         checks;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [4*DIGITS-1:0] a, input logic [4*DIGITS-1:0] b,
                      input logic s, input logic c,
                      input logic [4*DIGITS-1:0] e_sum, input logic e_cout, input logic e_err);
    int n;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 64'd1, 64'd0);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back({e_err, e_cout, e_sum});
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
      bus.in_valid = 1'b0;
      bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic         seen;
  logic         after_pop;
  logic [W-1:0] snap;
  logic [W-1:0] exp_v;
  int           acc_c;

  initial begin
    seen = 1'b0;
    after_pop = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        chk("in_ready_in_done", bus.in_ready, 1'b0);
        if (!seen) begin
          seen = 1'b1;
          snap = {bus.err, bus.cout, bus.sum};
          if (acc_q.size() != 0) begin
            acc_c = acc_q.pop_front();
            chk("latency", cyc - acc_c, DIGITS);
          end else begin
            chk("latency_no_accept", 64'd1, 64'd0);
          end
        end else begin
          chk("held_stable", {bus.err, bus.cout, bus.sum}, snap);
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            chk("sum",  bus.sum,  exp_v[4*DIGITS-1:0]);
            chk("cout", bus.cout, exp_v[4*DIGITS]);
            chk("err",  bus.err,  exp_v[4*DIGITS+1]);
          end else begin
            chk("unexpected_output", 64'd1, 64'd0);
          end
          seen = 1'b0;
          after_pop = 1'b1;
        end
      end else if (after_pop) begin
        after_pop = 1'b0;
        chk("idle_after_handshake", {bus.in_ready, bus.out_valid}, 2'b10);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    errors = 0;
    checks = 0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state",     state_dbg,     2'd0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sum",       bus.sum,       16'h0000);
    chk("rst_cout_err",  {bus.cout, bus.err}, 2'b00);

    // Directed vectors, hand-computed
    send(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    send(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h0999, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    send(16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
    send(16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0);
    send(16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0);
    send(16'h4321, 16'h4321, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h0009, 1'b1, 1'b0);  // cin ignored in sub
    send(16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h1304, 1'b0, 1'b1);  // invalid digit
    send(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);  // err clears
    wait_idle();

    // Backpressure: hold out_ready low for 3 cycles once out_valid is up
    bus.out_ready = 1'b0;
    send(16'h0500, 16'h0500, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("bp_valid_timeout", 64'd1, 64'd0);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle();

    // Reset while in CALC at digit index 2
    send(16'h7777, 16'h1111, 1'b0, 1'b0, 16'h8888, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_state", state_dbg, 2'd1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_state",     state_dbg,     2'd0);
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_sum",       bus.sum,       16'h0000);
    chk("abort_cout",      bus.cout,      1'b0);
    chk("abort_in_ready",  bus.in_ready,  1'b1);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
